// File: rtl/vote_pkg.sv
`default_nettype none
// ============================================================================
// vote_pkg : shared sizes, default timing and control-state encoding
// Revision : 1.0
// ============================================================================
package vote_pkg;

  localparam int NUM_CANDIDATES      = 4;
  localparam int VOTE_W              = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_LOCKOUT_CYCLES  = 100000000;

  typedef enum logic [1:0] {
    ST_ARMED        = 2'd0,
    ST_LOCKOUT      = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// button_debounce : accepts a new raw level after it holds for DEBOUNCE_CYCLES
// Revision : 1.0
// ============================================================================
module button_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             level_q, level_d;
  logic             block_q, block_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // After reset the input must be seen low once, so a button held through
  // reset cannot produce a press.
  always_comb begin
    level_d = level_q;
    block_d = block_q;
    cnt_d   = '0;
    if (block_q) begin
      block_d = raw;
    end else if (raw != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = raw;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      level_q <= 1'b0;
      block_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/vote_tally.sv
`default_nettype none
// ============================================================================
// vote_tally : four-candidate debounced vote counter with post-vote lockout
// Revision : 1.0
// ============================================================================
module vote_tally
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              candidate1_button,
  input  logic              candidate2_button,
  input  logic              candidate3_button,
  input  logic              candidate4_button,
  output logic              valid_vote_casted,
  output logic [VOTE_W-1:0] candidate1_vote,
  output logic [VOTE_W-1:0] candidate2_vote,
  output logic [VOTE_W-1:0] candidate3_vote,
  output logic [VOTE_W-1:0] candidate4_vote
);

  localparam int                LOCK_W    = cnt_width(LOCKOUT_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [VOTE_W-1:0] VOTE_MAX  = '1;

  logic [NUM_CANDIDATES-1:0] w_raw;
  logic [NUM_CANDIDATES-1:0] w_level;
  logic [NUM_CANDIDATES-1:0] prev_q;
  logic [NUM_CANDIDATES-1:0] press_q;

  state_e                                state_q, state_d;
  logic [LOCK_W-1:0]                     lock_cnt_q, lock_cnt_d;
  logic                                  valid_q, valid_d;
  logic [NUM_CANDIDATES-1:0][VOTE_W-1:0] totals_q, totals_d;

  assign w_raw = {candidate4_button, candidate3_button,
                  candidate2_button, candidate1_button};

  for (genvar gi = 0; gi < NUM_CANDIDATES; gi++) begin : g_debounce
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock(clock),
      .reset(reset),
      .raw  (w_raw[gi]),
      .level(w_level[gi])
    );
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    valid_d    = 1'b0;
    totals_d   = totals_q;
    case (state_q)
      ST_ARMED: begin
        if (!mode && (press_q != '0)) begin
          // A vote needs a single fresh press and no other button held down.
          if (is_onehot(press_q) && ((w_level & ~press_q) == '0)) begin
            valid_d = 1'b1;
            state_d = ST_LOCKOUT;
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
              if (press_q[i] && (totals_q[i] != VOTE_MAX)) begin
                totals_d[i] = totals_q[i] + VOTE_W'(1);
              end
            end
          end else begin
            state_d = ST_WAIT_RELEASE;
          end
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = ST_WAIT_RELEASE;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_level == '0) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q     <= '0;
      press_q    <= '0;
      state_q    <= ST_ARMED;
      lock_cnt_q <= '0;
      valid_q    <= 1'b0;
      totals_q   <= '0;
    end else begin
      prev_q     <= w_level;
      press_q    <= w_level & ~prev_q;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      valid_q    <= valid_d;
      totals_q   <= totals_d;
    end
  end

  assign valid_vote_casted = valid_q;
  assign candidate1_vote   = totals_q[0];
  assign candidate2_vote   = totals_q[1];
  assign candidate3_vote   = totals_q[2];
  assign candidate4_vote   = totals_q[3];

endmodule
`default_nettype wire

// File: tb/tb_vote_tally.sv
`default_nettype none
// ============================================================================
// tb_vote_tally : directed and randomized checks of vote_tally against a model
// Revision : 1.0
// ============================================================================
module tb_vote_tally;

  localparam int DEB  = 4;
  localparam int LOCK = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic       valid;
  logic [7:0] v1, v2, v3, v4;

  vote_tally #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mode             (mode),
    .candidate1_button(btn[0]),
    .candidate2_button(btn[1]),
    .candidate3_button(btn[2]),
    .candidate4_button(btn[3]),
    .valid_vote_casted(valid),
    .candidate1_vote  (v1),
    .candidate2_vote  (v2),
    .candidate3_vote  (v3),
    .candidate4_vote  (v4)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: debounced levels logged per cycle, press events and
  // lockout expressed as cycle timestamps.
  bit [3:0] deb_log [0:16383];
  int       m_run [4];
  bit       m_blk [4];
  int       m_tot [4];
  bit       m_valid;
  int       m_state;     // 0 armed, 1 lockout, 2 wait for release
  int       m_lock_end;
  bit [3:0] m_now, m_pr, m_oth;

  function automatic int idx(input int c);
    return c & 16383;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0;
        m_blk[i] = 1'b1;
        m_tot[i] = 0;
      end
      m_valid = 1'b0;
      m_state = 0;
      deb_log[idx(cyc)]     = 4'b0;
      deb_log[idx(cyc - 1)] = 4'b0;
      deb_log[idx(cyc - 2)] = 4'b0;
    end else begin
      m_now = deb_log[idx(cyc - 1)];
      for (int i = 0; i < 4; i++) begin
        if (m_blk[i]) begin
          if (!btn[i]) m_blk[i] = 1'b0;
          m_run[i] = 0;
        end else if (btn[i] != m_now[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_now[i] = btn[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pr    = deb_log[idx(cyc - 2)] & ~deb_log[idx(cyc - 3)];
      m_oth   = deb_log[idx(cyc - 1)] & ~m_pr;
      m_valid = 1'b0;
      case (m_state)
        0: if (!mode && m_pr != 4'b0) begin
             if ($countones(m_pr) == 1 && m_oth == 4'b0) begin
               for (int i = 0; i < 4; i++)
                 if (m_pr[i] && m_tot[i] < 255) m_tot[i]++;
               m_valid    = 1'b1;
               m_state    = 1;
               m_lock_end = cyc + LOCK;
             end else begin
               m_state = 2;
             end
           end
        1: if (cyc == m_lock_end) m_state = 2;
        default: if (deb_log[idx(cyc - 1)] == 4'b0) m_state = 0;
      endcase
      deb_log[idx(cyc)] = m_now;
    end
  end

  int d_pulses     = 0;
  int d_last_pulse = -1;
  bit prev_valid   = 1'b0;

  always @(negedge clock) begin
    if (valid === 1'b1) begin
      d_pulses++;
      d_last_pulse = cyc;
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL pulse_isolated cyc=%0d got=high_twice want=single", cyc);
      end
    end
    prev_valid = (valid === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic test_reset;
    reset = 1'b0; btn = 4'b0; mode = 1'b0;
    tick(3);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (v1 !== 8'd0) begin failures++; $display("FAIL reset_v1 got=%0d want=0", v1); end
    checks++; if (v2 !== 8'd0) begin failures++; $display("FAIL reset_v2 got=%0d want=0", v2); end
    checks++; if (v3 !== 8'd0) begin failures++; $display("FAIL reset_v3 got=%0d want=0", v3); end
    checks++; if (v4 !== 8'd0) begin failures++; $display("FAIL reset_v4 got=%0d want=0", v4); end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_press;
    int p0, rise;
    p0 = d_pulses;
    btn[1] = 1'b1; rise = cyc;
    tick(10);
    btn[1] = 1'b0;
    tick(30);
    checks++; if (d_pulses - p0 !== 1) begin failures++; $display("FAIL clean_pulses got=%0d want=1", d_pulses - p0); end
    checks++; if (d_last_pulse !== rise + 6) begin failures++; $display("FAIL clean_latency got=%0d want=%0d", d_last_pulse, rise + 6); end
    checks++; if (v2 !== 8'd1) begin failures++; $display("FAIL clean_v2 got=%0d want=1", v2); end
    checks++; if ({v1, v3, v4} !== 24'd0) begin failures++; $display("FAIL clean_others got=%0d/%0d/%0d want=0/0/0", v1, v3, v4); end
  endtask

  task automatic test_bounce;
    int p0, rise, exp1;
    p0 = d_pulses; exp1 = m_tot[0] + 1;
    for (int k = 0; k < 6; k++) begin
      btn[0] = ~btn[0];
      tick(2);
    end
    btn[0] = 1'b1; rise = cyc;
    tick(12);
    btn[0] = 1'b0;
    tick(30);
    checks++; if (d_pulses - p0 !== 1) begin failures++; $display("FAIL bounce_pulses got=%0d want=1", d_pulses - p0); end
    checks++; if (d_last_pulse !== rise + 6) begin failures++; $display("FAIL bounce_latency got=%0d want=%0d", d_last_pulse, rise + 6); end
    checks++; if (v1 !== 8'(exp1)) begin failures++; $display("FAIL bounce_v1 got=%0d want=%0d", v1, exp1); end
  endtask

  task automatic test_lockout_release;
    int p0, base, r;
    p0 = d_pulses; base = m_tot[2];
    btn[2] = 1'b1; tick(50); btn[2] = 1'b0; tick(10);
    btn[2] = 1'b1; tick(10); btn[2] = 1'b0; tick(30);
    checks++; if (d_pulses - p0 !== 2) begin failures++; $display("FAIL hold_release_pulses got=%0d want=2", d_pulses - p0); end
    checks++; if (v3 !== 8'(base + 2)) begin failures++; $display("FAIL hold_release_v3 got=%0d want=%0d", v3, base + 2); end
    r = cyc;
    btn[2] = 1'b1; wait_until(r + 8); btn[2] = 1'b0;
    wait_until(r + 14); btn[2] = 1'b1;
    wait_until(r + 40); btn[2] = 1'b0;
    tick(30);
    checks++; if (d_pulses - p0 !== 3) begin failures++; $display("FAIL lockout_repress_pulses got=%0d want=3", d_pulses - p0); end
    checks++; if (v3 !== 8'(base + 3)) begin failures++; $display("FAIL lockout_repress_v3 got=%0d want=%0d", v3, base + 3); end
  endtask

  task automatic test_conflict_mode;
    int p0, b0, b1, b2, b3, r, e;
    p0 = d_pulses; b0 = m_tot[0]; b1 = m_tot[1]; b2 = m_tot[2]; b3 = m_tot[3];
    btn[0] = 1'b1; btn[3] = 1'b1; tick(10); btn = 4'b0; tick(30);
    checks++; if (d_pulses - p0 !== 0) begin failures++; $display("FAIL conflict_pulses got=%0d want=0", d_pulses - p0); end
    checks++; if (v1 !== 8'(b0) || v4 !== 8'(b3)) begin failures++; $display("FAIL conflict_totals got=%0d/%0d want=%0d/%0d", v1, v4, b0, b3); end
    mode = 1'b1; btn[1] = 1'b1; tick(10); btn = 4'b0; tick(30); mode = 1'b0;
    checks++; if (d_pulses - p0 !== 0) begin failures++; $display("FAIL result_mode_pulses got=%0d want=0", d_pulses - p0); end
    checks++; if (v2 !== 8'(b1)) begin failures++; $display("FAIL result_mode_v2 got=%0d want=%0d", v2, b1); end
    // Re-press one cycle too early: lockout must not be shortened by mode toggling.
    r = cyc; e = r + 6;
    btn[2] = 1'b1; wait_until(r + 8); btn[2] = 1'b0;
    wait_until(e + 3); mode = 1'b1; wait_until(e + 8); mode = 1'b0;
    wait_until(e + 16); btn[2] = 1'b1; wait_until(e + 26); btn[2] = 1'b0;
    wait_until(e + 60);
    checks++; if (d_pulses - p0 !== 1) begin failures++; $display("FAIL lockout_not_short got=%0d want=1", d_pulses - p0); end
    // Earliest re-press that can count: lockout must not be extended either.
    r = cyc; e = r + 6;
    btn[2] = 1'b1; wait_until(r + 8); btn[2] = 1'b0;
    wait_until(e + 3); mode = 1'b1; wait_until(e + 8); mode = 1'b0;
    wait_until(e + 17); btn[2] = 1'b1; wait_until(e + 27); btn[2] = 1'b0;
    wait_until(e + 60);
    checks++; if (d_pulses - p0 !== 3) begin failures++; $display("FAIL lockout_not_long got=%0d want=3", d_pulses - p0); end
    checks++; if (d_last_pulse !== e + 23) begin failures++; $display("FAIL lockout_end_time got=%0d want=%0d", d_last_pulse, e + 23); end
    checks++; if (v3 !== 8'(b2 + 3)) begin failures++; $display("FAIL lockout_v3 got=%0d want=%0d", v3, b2 + 3); end
  endtask

  task automatic test_saturation;
    int p0;
    reset = 1'b0; tick(2); reset = 1'b1; tick(2);
    p0 = d_pulses;
    for (int k = 0; k < 256; k++) begin
      btn[3] = 1'b1; tick(8); btn[3] = 1'b0; tick(28);
    end
    checks++; if (d_pulses - p0 !== 256) begin failures++; $display("FAIL sat_pulses got=%0d want=256", d_pulses - p0); end
    checks++; if (v4 !== 8'd255) begin failures++; $display("FAIL sat_v4 got=%0d want=255", v4); end
    checks++; if (v4 !== 8'(m_tot[3])) begin failures++; $display("FAIL sat_model got=%0d want=%0d", v4, m_tot[3]); end
  endtask

  task automatic test_reset_mid;
    int p0, r;
    p0 = d_pulses; r = cyc;
    btn[0] = 1'b1; wait_until(r + 10);
    checks++; if (d_pulses - p0 !== 1) begin failures++; $display("FAIL pre_reset_pulse got=%0d want=1", d_pulses - p0); end
    reset = 1'b0; tick(1); reset = 1'b1;
    checks++; if ({v1, v2, v3, v4} !== 32'd0) begin failures++; $display("FAIL midlock_reset_totals got=%0d/%0d/%0d/%0d want=0", v1, v2, v3, v4); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midlock_reset_valid got=%b want=0", valid); end
    wait_until(r + 12); btn[0] = 1'b0;
    p0 = d_pulses;
    btn[1] = 1'b1; tick(2);
    reset = 1'b0; tick(1); reset = 1'b1;
    tick(25);
    checks++; if (d_pulses - p0 !== 0) begin failures++; $display("FAIL held_through_reset got=%0d want=0", d_pulses - p0); end
    btn[1] = 1'b0; tick(6);
    btn[1] = 1'b1; r = cyc; tick(10); btn[1] = 1'b0; tick(30);
    checks++; if (d_last_pulse !== r + 6) begin failures++; $display("FAIL repress_after_reset got=%0d want=%0d", d_last_pulse, r + 6); end
    checks++; if ({v1, v2} !== {8'd0, 8'd1}) begin failures++; $display("FAIL repress_totals got=%0d/%0d want=0/1", v1, v2); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      tick(1);
      checks++; if (valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, valid, m_valid); end
      checks++; if ({v1, v2, v3, v4} !== {8'(m_tot[0]), 8'(m_tot[1]), 8'(m_tot[2]), 8'(m_tot[3])})
        begin failures++; $display("FAIL rand_totals cyc=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", cyc, v1, v2, v3, v4, m_tot[0], m_tot[1], m_tot[2], m_tot[3]); end
    end
    reset = 1'b1; btn = 4'b0; mode = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_lockout_release();
    test_conflict_mode();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vote_tally.md
VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1000000, cycles a raw button must hold a new level before that level is accepted.
REQ-002 Parameter: LOCKOUT_CYCLES, 100000000, cycles after a valid vote during which new presses are ignored.
REQ-003 Port: clock  input  1  sole clock; all logic rising-edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 Port: mode  input  1  0 = voting, 1 = result; votes accepted only when 0.
REQ-006 Port: candidate1_button..candidate4_button  input  1 each  raw, undebounced push-buttons, active-high.
REQ-007 Port: valid_vote_casted  output  1  one-cycle pulse per accepted vote.
REQ-008 Port: candidate1_vote..candidate4_vote  output  8 each  per-candidate vote totals.

Function
REQ-009 Each button SHALL pass through a debouncer: the debounced level changes only after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening return restarts the count.
REQ-010 A press event SHALL be a 0->1 transition of a debounced level, detected one cycle after the debounced level changes.
REQ-011 Control FSM states: ARMED, LOCKOUT, WAIT_RELEASE.
REQ-012 In ARMED with mode=0, a press event on exactly one button, with every other debounced level 0, SHALL be a valid vote.
REQ-013 A valid vote SHALL increment that candidate's total and assert valid_vote_casted on the cycle after the press event; the FSM SHALL then enter LOCKOUT.
REQ-014 Simultaneous press events, or a press while another debounced button is high, SHALL NOT count; the FSM SHALL go to WAIT_RELEASE.
REQ-015 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, ignoring all presses, then go to WAIT_RELEASE.
REQ-016 WAIT_RELEASE SHALL return to ARMED on the first cycle on which all four debounced levels are 0.
REQ-017 With mode=1, presses SHALL NOT count and totals SHALL hold; the FSM SHALL continue its timing and transitions.
REQ-018 A mode change during LOCKOUT SHALL NOT shorten or extend the lockout.
REQ-019 Totals SHALL saturate at 255; a valid vote at 255 still pulses valid_vote_casted and enters LOCKOUT, but the total stays 255.
REQ-020 All outputs SHALL be registered; valid_vote_casted SHALL never be high on two consecutive cycles.

Reset
REQ-021 With reset=0 at a clock edge, all totals SHALL become 0, valid_vote_casted 0, FSM ARMED, and debounce and lockout counters 0.
REQ-022 Debounced levels SHALL reset to 0, so a button held through reset registers no press until it is released and pressed again.
REQ-023 Reset mid-lockout or mid-debounce SHALL abort the operation with no pulse and no count.

Structure
REQ-024 Package vote_pkg SHALL hold NUM_CANDIDATES=4, VOTE_W=8, the default DEBOUNCE_CYCLES and LOCKOUT_CYCLES values, and the FSM state encoding.
REQ-025 Counter widths SHALL be derived from the parameters (clog2), not hard-coded.
REQ-026 Sub-module button_debounce (clock, reset, raw, level), instantiated once per candidate, SHALL implement REQ-009 and REQ-022.

Verification
All scenarios run with DEBOUNCE_CYCLES=4 and LOCKOUT_CYCLES=20.
REQ-027 Clean press: mode=0, button2 high 10 cycles -> one valid_vote_casted pulse 6 cycles after raw rise; candidate2_vote=1; others 0.
REQ-028 Bounce: button1 toggles every 2 cycles for 12 cycles, then steady high -> exactly one count, with the pulse 6 cycles after the final rise.
REQ-029 Lockout and release: press button3, hold 50 cycles, release, press again -> total 2; a re-press inside the 20-cycle lockout adds nothing.
REQ-030 Conflict and mode: buttons1 and 4 rise on the same cycle -> no pulse, totals unchanged; press under mode=1 -> no count; mode toggled mid-lockout -> lockout ends at cycle 20.
REQ-031 Saturation and reset: 256 valid votes on button4 -> candidate4_vote=255 and 256 pulses; reset=0 mid-lockout -> all totals 0 and no pulse.
